// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite responder bus bundle: master drives address/control/write data,
// slave returns ready, read data and response.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hr_readyout;
  logic [31:0] hr_data;
  logic        hresp;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output hr_readyout, hr_data, hresp
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  hr_readyout, hr_data, hresp
  );
endinterface

// File: rtl/ahb_addr_check.sv
// Address-phase legality check and little-endian byte-lane strobe generation
// for a window of 2**AW bytes at BASE_ADDR.
module ahb_addr_check
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          AW        = 10
) (
  input  logic [31:0] i_haddr,
  input  logic [2:0]  i_hsize,
  output logic        o_err,
  output logic [3:0]  o_strb
);

  localparam logic [31:0] WIN_MASK = ~((32'd1 << AW) - 32'd1);

  logic w_out_of_win;
  logic w_misalign;

  assign w_out_of_win = (i_haddr & WIN_MASK) != (BASE_ADDR & WIN_MASK);

  always_comb begin
    o_strb     = 4'b0000;
    w_misalign = 1'b0;
    case (i_hsize)
      HSIZE_BYTE: o_strb = 4'b0001 << i_haddr[1:0];
      HSIZE_HALF: begin
        o_strb     = i_haddr[1] ? 4'b1100 : 4'b0011;
        w_misalign = i_haddr[0];
      end
      HSIZE_WORD: begin
        o_strb     = 4'b1111;
        w_misalign = |i_haddr[1:0];
      end
      default:    w_misalign = 1'b1;
    endcase
  end

  assign o_err = w_out_of_win | w_misalign;

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-organised memory responder with programmable wait states,
// byte-lane writes and a two-cycle ERROR response.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_slave_mem_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH) + 2;
  localparam int         IW       = AW - 2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e         r_state, w_nstate;
  logic [3:0]     r_cnt, w_ncnt;
  logic [IW-1:0]  r_idx;
  logic           r_write;
  logic [3:0]     r_strb;
  logic [31:0]    r_mem [DEPTH];

  logic           w_accept, w_take, w_done, w_err, w_ready, w_resp;
  logic [3:0]     w_strb;

  ahb_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .AW        (AW)
  ) u_addr_check (
    .i_haddr (bus.haddr),
    .i_hsize (bus.hsize),
    .o_err   (w_err),
    .o_strb  (w_strb)
  );

  assign w_accept = bus.hsel & bus.hready_in &
                    ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign w_done   = (r_state == ST_DATA) && (r_cnt == 4'd0);
  // A new address phase may only be taken when the current data phase is finishing.
  assign w_take   = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_done;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ready  = 1'b1;
    w_resp   = HRESP_OKAY;
    case (r_state)
      ST_DATA: begin
        w_ready = (r_cnt == 4'd0);
        if (r_cnt != 4'd0) w_ncnt = r_cnt - 4'd1;
      end
      ST_ERR1: begin
        w_ready  = 1'b0;
        w_resp   = HRESP_ERROR;
        w_nstate = ST_ERR2;
      end
      ST_ERR2: w_resp = HRESP_ERROR;
      default: ;
    endcase
    if (w_take) begin
      if (w_accept) begin
        w_nstate = w_err ? ST_ERR1 : ST_DATA;
        w_ncnt   = w_err ? 4'd0 : WAIT_CNT;
      end else begin
        w_nstate = ST_IDLE;
        w_ncnt   = 4'd0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (w_take && w_accept) begin
      r_idx   <= bus.haddr[AW-1:2];
      r_write <= bus.hwrite;
      r_strb  <= w_strb;
    end
  end

  // Reset at the completion edge aborts the write along with the transfer.
  always_ff @(posedge hclk) begin
    if (w_done && r_write && !hreset) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  assign bus.hr_readyout = w_ready;
  assign bus.hresp       = w_resp;
  assign bus.hr_data     = (w_done && !r_write) ? r_mem[r_idx] : 32'd0;

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder that terminates transfers from the bus master. It provides a word-organised on-chip memory window at BASE_ADDR.
- Captures address/control in the address phase and completes the transfer in the following data phase.
- Supports programmable wait states, byte, halfword and word writes, and a two-cycle ERROR response.
- Sits on the AHB side of the AHB2APB bridge subsystem as the bench/system target for master bring-up.

Parameters:
BASE_ADDR, 32'h8000_0000, base of decoded window (aligned to window size)
DEPTH, 256, number of 32-bit words; power of 2, min 4
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hreset  in  1  synchronous reset, active-high
hsel  in  1  slave select from decoder
haddr  in  32  byte address (address phase)
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write, 0=read
hsize  in  3  0=byte, 1=halfword, 2=word
hwdata  in  32  write data (data phase)
hready_in  in  1  bus-level HREADY; previous data phase complete
hr_readyout  out  1  slave HREADYOUT
hr_data  out  32  read data
hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (hreset=1 at edge): state=IDLE, hr_readyout=1, hresp=0, hr_data=0, wait counter=0, pending transfer dropped. Memory contents not reset (undefined until written).
- Accept condition at edge: hsel & hready_in & htrans[1]. On accept, latch haddr, hwrite, hsize.
- IDLE or BUSY with hsel, or hsel=0: no transfer. Next cycle is IDLE state with readyout=1, OKAY.
- Error check at accept, evaluated by the address check:
  - out of window: haddr[31:AW] != BASE_ADDR[31:AW], where AW=log2(DEPTH)+2
  - hsize>2
  - halfword with haddr[0]=1
  - word with haddr[1:0]!=0
- FSM states IDLE, DATA, ERR1, ERR2. Transitions:
  - IDLE/DATA-complete/ERR2, accept with error -> ERR1
  - same, accept without error -> DATA with cnt=WAIT_STATES
  - same, no accept -> IDLE
  - DATA, cnt!=0 -> DATA, cnt-1
  - ERR1 -> ERR2
- Outputs by state:
  - IDLE: readyout=1, hresp=0
  - DATA: readyout=(cnt==0), hresp=0
  - ERR1: readyout=0, hresp=1
  - ERR2: readyout=1, hresp=1
- Data-phase completion = DATA & cnt==0.
  - Write: at the completion edge, update only enabled byte lanes from hwdata (AHB lane mapping, little-endian). Byte: lane haddr[1:0]. Halfword: lanes {haddr[1],0}+0..1. Word: all four.
  - Read: hr_data = mem[latched word index] combinationally during completion cycle; hr_data=0 in all other cycles. Full word is returned; the master selects lanes.
- Pipelining: a new address phase is accepted in the completion cycle (and in ERR2), giving back-to-back zero-wait transfers. SEQ bursts with WAIT_STATES=0 complete one beat per cycle.
- Write then read to the same address on consecutive transfers returns the new data (write lands at the edge before the read data phase).
- Address phases presented while readyout=0 (DATA cnt>0, ERR1) are ignored, because hready_in is low.
- Word index = latched haddr[AW-1:2]. No wrap logic; incrementing bursts crossing the window end error on the out-of-window beat only.
- Synchronous reset mid-transfer aborts it. A write not yet at its completion edge does not modify memory.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD
  - HRESP_OKAY/ERROR
  - FSM state typedef/encoding
- One sub-module, ahb_addr_check (combinational): inputs haddr, hsize; outputs err and 4-bit byte strobe. It is reused later by the bridge's AHB slave interface.
- FSM, counter and memory stay in ahb_slave_mem.

Test Plan:
- Reset: hold hreset 2 cycles mid-burst -> hr_readyout=1, hresp=0, hr_data=0 the cycle after release. Subsequent NONSEQ is accepted normally.
- Single write/read, WAIT_STATES=0: word write 32'h0000_0024 at 32'h8000_0000, then read -> readyout never low; hr_data=32'h0000_0024 in read data phase.
- Byte INCR4 write: NONSEQ then SEQ×3 to 8000_0000..8000_0003, hsize=0, bytes 11,22,33,44 on correct lanes -> read of 8000_0000 gives 32'h4433_2211.
- Wait states, WAIT_STATES=2: single read -> hr_readyout low exactly 2 cycles, high with valid data on the 3rd data-phase cycle. The next NONSEQ is accepted only in that cycle.
- Error: NONSEQ to 32'h9000_0000 -> cycle1 readyout=0/hresp=1, cycle2 readyout=1/hresp=1, memory unchanged. Misaligned halfword at 8000_0001 gives the same response.
- Pipelining/hazard: back-to-back word write 32'hDEAD_BEEF to 8000_0004 then read 8000_0004 with no idle -> read returns 32'hDEAD_BEEF. IDLE/BUSY with hsel=1 give OKAY, no memory change.
